// File: rtl/mul_div_pkg.sv
// Shared types for the iterative multiply/divide sequencer.
package mul_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef enum logic {
    OP_MULU,
    OP_DIVU
  } op_t;

endpackage

// File: rtl/mul_div_datapath.sv
// One radix-2 iteration of shift-add multiply or restoring divide.
// Purely combinational so the iteration step can be swapped without touching control.
module mul_div_datapath
  import mul_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  always_comb begin
    sum    = {1'b0, hi} + (lo[0] ? {1'b0, b} : {(WIDTH + 1){1'b0}});
    rem_sh = {hi, lo[WIDTH-1]};
    // Remainder stays below the divisor, so bit WIDTH of the trial is its sign.
    trial  = rem_sh - {1'b0, b};
    hi_nxt = hi;
    lo_nxt = lo;
    if (op == OP_MULU) begin
      hi_nxt = sum[WIDTH:1];
      lo_nxt = {sum[0], lo[WIDTH-1:1]};
    end else if (!trial[WIDTH]) begin
      hi_nxt = trial[WIDTH-1:0];
      lo_nxt = {lo[WIDTH-2:0], 1'b1};
    end else begin
      hi_nxt = rem_sh[WIDTH-1:0];
      lo_nxt = {lo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mul_div_ctrl.sv
// Iterative unsigned MULU/DIVU sequencer: IDLE -> RUN (WIDTH cycles) -> DONE.
// The hi/lo accumulator doubles as the result registers and holds until the next accept.
module mul_div_ctrl
  import mul_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             resp_valid,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           state;
  op_t              op_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_nxt;
  logic [WIDTH-1:0] lo_nxt;
  logic [CNT_W-1:0] cnt;

  mul_div_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .op    (op_q),
    .hi    (hi_q),
    .lo    (lo_q),
    .b     (b_q),
    .hi_nxt(hi_nxt),
    .lo_nxt(lo_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      op_q       <= OP_MULU;
      b_q        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      cnt        <= '0;
    end else if (flush) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            state     <= RUN;
            req_ready <= 1'b0;
            op_q      <= op_t'(req_op);
            b_q       <= op_b;
            hi_q      <= '0;
            lo_q      <= op_a;
            cnt       <= '0;
          end
        end
        RUN: begin
          hi_q <= hi_nxt;
          lo_q <= lo_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            state      <= DONE;
            resp_valid <= 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign result_lo = lo_q;
  assign result_hi = hi_q;

endmodule

// File: tb/tb_mul_div_ctrl.sv
// Self-checking bench for mul_div_ctrl: directed cases plus randomized traffic
// compared every cycle against a cycle-count/arithmetic reference model.
module tb_mul_div_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic         req_op;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         flush;
  logic         resp_valid;
  logic [W-1:0] result_lo;
  logic [W-1:0] result_hi;

  int tests = 0;
  int fails = 0;

  mul_div_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .op_a      (op_a),
    .op_b      (op_b),
    .flush     (flush),
    .resp_valid(resp_valid),
    .result_lo (result_lo),
    .result_hi (result_hi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result {hi, lo} straight from the arithmetic definition.
  function automatic logic [63:0] ref_res(input logic op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [63:0] r;
    if (!op) r = {32'h0, a} * {32'h0, b};
    else if (b == 0) r = {a, 32'hFFFF_FFFF};
    else r = {a % b, a / b};
    return r;
  endfunction

  // Reference model: busy = cycles left before the block is idle again.
  int          cyc = 0;
  int          busy = 0;
  bit          started = 0;
  bit          known = 0;
  logic [63:0] exp_res = '0;
  logic [63:0] pend = '0;
  int          dut_resp_cnt = 0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      started = 1;
      busy    = 0;
      known   = 1;
      exp_res = '0;
    end else if (flush) begin
      if (busy > 1) known = 0;
      busy = 0;
    end else if (busy == 0) begin
      if (req_valid) begin
        busy  = W + 1;
        pend  = ref_res(req_op, op_a, op_b);
        known = 0;
      end
    end else begin
      busy--;
      if (busy == 1) begin
        exp_res = pend;
        known   = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("req_ready", {63'b0, req_ready}, {63'b0, busy == 0});
      chk("resp_valid", {63'b0, resp_valid}, {63'b0, busy == 1});
      if (known) chk("result", {result_hi, result_lo}, exp_res);
      if (resp_valid) dut_resp_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!req_ready && n < 200) begin
      step();
      n++;
    end
    chk("idle_wait", {63'b0, req_ready}, 64'd1);
  endtask

  // Issue one request from idle; check latency, ready-low window and literal result.
  task automatic run_op(input string name, input logic op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_lo,
                        input logic [W-1:0] exp_hi);
    int n = 1;
    int ready_hi = 0;
    wait_idle();
    req_valid = 1'b1;
    req_op    = op;
    op_a      = a;
    op_b      = b;
    step();
    req_valid = 1'b0;
    while (!resp_valid && n < 100) begin
      if (req_ready) ready_hi++;
      step();
      n++;
    end
    if (req_ready) ready_hi++;
    chk({name, "_latency"}, 64'(n), 64'(W + 1));
    chk({name, "_ready_low"}, 64'(ready_hi), 64'd0);
    chk({name, "_lo"}, {32'h0, result_lo}, {32'h0, exp_lo});
    chk({name, "_hi"}, {32'h0, result_hi}, {32'h0, exp_hi});
    step();
    chk({name, "_ready_again"}, {63'b0, req_ready}, 64'd1);
    chk({name, "_lo_hold"}, {32'h0, result_lo}, {32'h0, exp_lo});
  endtask

  function automatic logic [W-1:0] rnd_opnd();
    logic [W-1:0] v;
    case ($urandom_range(0, 3))
      0: v = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 3));
      1: v = W'($urandom_range(0, 255));
      2: v = $urandom;
      default: v = 32'hFFFF_FFFF - W'($urandom_range(0, 15));
    endcase
    return v;
  endfunction

  initial begin
    int n_acc;
    int last_acc;
    int guard;
    int resp0;
    bit prev_ready;

    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 1'b0;
    op_a      = '0;
    op_b      = '0;
    flush     = 1'b0;

    // Pin the reference arithmetic to hand-computed values.
    chk("model_mul_7x6", ref_res(1'b0, 32'd7, 32'd6), 64'd42);
    chk("model_mul_max", ref_res(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
    chk("model_div_100_7", ref_res(1'b1, 32'd100, 32'd7), {32'd2, 32'd14});
    chk("model_div_by_0", ref_res(1'b1, 32'd5, 32'd0), {32'd5, 32'hFFFF_FFFF});

    step();
    step();
    reset = 1'b0;
    chk("reset_ready", {63'b0, req_ready}, 64'd1);
    chk("reset_resp", {63'b0, resp_valid}, 64'd0);
    chk("reset_result", {result_hi, result_lo}, 64'd0);

    run_op("mulu_7x6", 1'b0, 32'd7, 32'd6, 32'd42, 32'd0);
    run_op("mulu_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("divu_100_7", 1'b1, 32'd100, 32'd7, 32'd14, 32'd2);
    run_op("divu_5_0", 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);

    // Flush mid-operation: accept at cycle 0, flush during cycle 10.
    wait_idle();
    resp0     = dut_resp_cnt;
    req_valid = 1'b1;
    req_op    = 1'b0;
    op_a      = 32'd123;
    op_b      = 32'd456;
    step();
    req_valid = 1'b0;
    for (int i = 1; i < 10; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_ready", {63'b0, req_ready}, 64'd1);
    for (int i = 0; i < 40; i++) step();
    chk("flush_no_resp", 64'(dut_resp_cnt - resp0), 64'd0);
    run_op("divu_9_3", 1'b1, 32'd9, 32'd3, 32'd3, 32'd0);

    // Reset during RUN.
    req_valid = 1'b1;
    req_op    = 1'b0;
    op_a      = 32'hDEAD_BEEF;
    op_b      = 32'h1234_5678;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrun_reset_ready", {63'b0, req_ready}, 64'd1);
    chk("midrun_reset_resp", {63'b0, resp_valid}, 64'd0);
    chk("midrun_reset_result", {result_hi, result_lo}, 64'd0);

    // Request together with flush in IDLE is not accepted.
    req_valid = 1'b1;
    flush     = 1'b1;
    step();
    req_valid = 1'b0;
    flush     = 1'b0;
    chk("flush_blocks_accept", {63'b0, req_ready}, 64'd1);

    // Held request: exactly one accept per WIDTH+2 cycles, one response each.
    wait_idle();
    resp0      = dut_resp_cnt;
    req_valid  = 1'b1;
    req_op     = 1'($urandom);
    op_a       = rnd_opnd();
    op_b       = rnd_opnd();
    prev_ready = 1'b1;
    n_acc      = 0;
    last_acc   = 0;
    guard      = 0;
    while (n_acc < 6 && guard < 400) begin
      step();
      guard++;
      if (prev_ready && !req_ready) begin
        if (n_acc > 0) chk("accept_spacing", 64'(cyc - last_acc), 64'(W + 2));
        last_acc = cyc;
        n_acc++;
        req_op = 1'($urandom);
        op_a   = rnd_opnd();
        op_b   = rnd_opnd();
      end
      prev_ready = req_ready;
    end
    req_valid = 1'b0;
    wait_idle();
    chk("held_accepts", 64'(n_acc), 64'd6);
    chk("held_responses", 64'(dut_resp_cnt - resp0), 64'd6);

    // Free-running random traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      req_valid = ($urandom_range(0, 2) == 0);
      req_op    = 1'($urandom);
      op_a      = rnd_opnd();
      op_b      = rnd_opnd();
      flush     = ($urandom_range(0, 149) == 0);
      reset     = ($urandom_range(0, 399) == 0);
      step();
    end
    req_valid = 1'b0;
    flush     = 1'b0;
    reset     = 1'b0;
    wait_idle();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
